// File: rtl/hazard_forward_unit.sv
// Data-hazard unit: per-operand EX forwarding selects plus
// load-use stall FSM and a saturating stall-cycle counter.
module hazard_forward_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int NUM_SRC           = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
  input  logic [NUM_SRC-1:0]            rs_used_id,
  input  logic [REG_ADDR_W-1:0]         rd_ex,
  input  logic                          mem_read_ex,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex,
  input  logic [REG_ADDR_W-1:0]         rd_mem,
  input  logic                          reg_write_mem,
  input  logic [REG_ADDR_W-1:0]         rd_wb,
  input  logic                          reg_write_wb,
  input  logic                          hold,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall,
  output logic                          flush_ex,
  output logic [CNT_W-1:0]              stall_count
);

  typedef enum logic {
    IDLE,
    STALL
  } state_e;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;
  localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_e          state_q;
  logic [2:0]      rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic            haz;
  logic            mem_ok;
  logic            wb_ok;

  assign mem_ok = reg_write_mem && (rd_mem != X0);
  assign wb_ok  = reg_write_wb && (rd_wb != X0);

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_ok && rd_mem == rs_ex[i*REG_ADDR_W +: REG_ADDR_W])
        fwd_sel[2*i +: 2] = 2'b01;
      else if (wb_ok && rd_wb == rs_ex[i*REG_ADDR_W +: REG_ADDR_W])
        fwd_sel[2*i +: 2] = 2'b10;
    end
  end

  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_id[i] && rs_id[i*REG_ADDR_W +: REG_ADDR_W] == rd_ex)
        haz = 1'b1;
    end
    haz = haz && mem_read_ex && (rd_ex != X0);
  end

  // Reset masks stall even though state is already cleared, so
  // the output is clean for the whole time arst is held.
  assign stall    = !arst && ((state_q == STALL) || haz);
  assign flush_ex = stall && !hold;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      rem_q   <= 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (haz && !hold && LOAD_STALL_CYCLES > 1) begin
            state_q <= STALL;
            rem_q   <= REM_INIT;
          end
        end
        STALL: begin
          if (!hold) begin
            if (rem_q == 3'd1) begin
              state_q <= IDLE;
              rem_q   <= 3'd0;
            end else begin
              rem_q <= rem_q - 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rem_q   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      cnt_q <= '0;
    else if (stall && cnt_q != '1)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; two instances
// (3-cycle/32-bit and 2-cycle/4-bit) checked against a window model.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        arst;
  logic [9:0]  rs_id;
  logic [1:0]  rs_used_id;
  logic [4:0]  rd_ex;
  logic        mem_read_ex;
  logic [9:0]  rs_ex;
  logic [4:0]  rd_mem;
  logic        reg_write_mem;
  logic [4:0]  rd_wb;
  logic        reg_write_wb;
  logic        hold;

  logic [3:0]  fwd3, fwd2;
  logic        stall3, stall2;
  logic        flush3, flush2;
  logic [31:0] cnt3;
  logic [3:0]  cnt2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .REG_ADDR_W(5), .NUM_SRC(2),
    .LOAD_STALL_CYCLES(3), .CNT_W(32)
  ) u_dut3 (
    .clk(clk), .arst(arst),
    .rs_id(rs_id), .rs_used_id(rs_used_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .rs_ex(rs_ex), .rd_mem(rd_mem),
    .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .hold(hold), .fwd_sel(fwd3), .stall(stall3),
    .flush_ex(flush3), .stall_count(cnt3)
  );

  hazard_forward_unit #(
    .REG_ADDR_W(5), .NUM_SRC(2),
    .LOAD_STALL_CYCLES(2), .CNT_W(4)
  ) u_dut2 (
    .clk(clk), .arst(arst),
    .rs_id(rs_id), .rs_used_id(rs_used_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .rs_ex(rs_ex), .rd_mem(rd_mem),
    .reg_write_mem(reg_write_mem),
    .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .hold(hold), .fwd_sel(fwd2), .stall(stall2),
    .flush_ex(flush2), .stall_count(cnt2)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fwd_model();
    logic [3:0] r;
    logic [4:0] s;
    r = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      s = rs_ex[i*5 +: 5];
      if (reg_write_mem && rd_mem != 0 && rd_mem == s)
        r[2*i +: 2] = 2'b01;
      else if (reg_write_wb && rd_wb != 0 && rd_wb == s)
        r[2*i +: 2] = 2'b10;
    end
    return r;
  endfunction

  function automatic logic haz_model();
    logic h;
    h = 1'b0;
    for (int i = 0; i < 2; i++)
      if (rs_used_id[i] && rs_id[i*5 +: 5] == rd_ex)
        h = 1'b1;
    return h && mem_read_ex && rd_ex != 0;
  endfunction

  // Model: w = stall cycles still owed after the current one.
  int      lsc  [2] = '{3, 2};
  longint  cmax [2] = '{64'hFFFF_FFFF, 64'd15};
  int      w    [2] = '{0, 0};
  longint  cnt  [2] = '{0, 0};

  always @(negedge clk) begin
    logic [3:0] ef;
    logic       es;
    logic       act_s, act_f;
    longint     act_c;
    ef = fwd_model();
    chk("fwd_sel3", 64'(fwd3), 64'(ef));
    chk("fwd_sel2", 64'(fwd2), 64'(ef));
    for (int k = 0; k < 2; k++) begin
      if (arst) begin
        w[k]   = 0;
        cnt[k] = 0;
      end
      es = !arst && (w[k] > 0 || haz_model());
      act_s = (k == 0) ? stall3 : stall2;
      act_f = (k == 0) ? flush3 : flush2;
      act_c = (k == 0) ? longint'(cnt3) : longint'(cnt2);
      chk(k == 0 ? "stall3" : "stall2", 64'(act_s), 64'(es));
      chk(k == 0 ? "flush3" : "flush2", 64'(act_f),
          64'(es && !hold));
      chk(k == 0 ? "count3" : "count2", 64'(act_c), 64'(cnt[k]));
      if (!arst) begin
        if (es && cnt[k] < cmax[k]) cnt[k]++;
        if (w[k] > 0) begin
          if (!hold) w[k]--;
        end else if (haz_model() && !hold) begin
          w[k] = lsc[k] - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst = 1'b1;
    rs_id = '0; rs_used_id = '0; rd_ex = '0; mem_read_ex = 1'b0;
    rs_ex = '0; rd_mem = '0; reg_write_mem = 1'b0;
    rd_wb = '0; reg_write_wb = 1'b0; hold = 1'b0;
    repeat (2) tick();
    chk("rst_stall", 64'(stall3), 64'd0);
    chk("rst_count", 64'(cnt3), 64'd0);
    arst = 1'b0;
    tick();

    rs_ex = {5'd5, 5'd5}; rd_mem = 5'd5; rd_wb = 5'd5;
    reg_write_mem = 1'b1; reg_write_wb = 1'b1;
    #1 chk("prio_mem", 64'(fwd3), 64'b0101);
    tick();
    reg_write_mem = 1'b0;
    #1 chk("prio_wb", 64'(fwd3), 64'b1010);
    tick();

    rs_ex = {5'd4, 5'd0}; rd_mem = 5'd0; reg_write_mem = 1'b1;
    rd_wb = 5'd0; reg_write_wb = 1'b1;
    #1 chk("x0_mem", 64'(fwd3[1:0]), 64'b00);
    tick();
    rs_ex = {5'd3, 5'd3}; rd_mem = 5'd9; rd_wb = 5'd3;
    reg_write_wb = 1'b0;
    #1 chk("wb_en_off", 64'(fwd3), 64'b0000);
    tick();

    rs_ex = {5'd2, 5'd1}; rd_mem = 5'd1; rd_wb = 5'd2;
    reg_write_mem = 1'b1; reg_write_wb = 1'b1;
    #1 chk("indep_ops", 64'(fwd3), 64'b1001);
    tick();

    rd_ex = 5'd7; rs_id = {5'd7, 5'd0}; rs_used_id = 2'b11;
    mem_read_ex = 1'b1;
    #1 chk("lu_t0_stall", 64'(stall3), 64'd1);
    chk("lu_t0_flush", 64'(flush3), 64'd1);
    tick();
    mem_read_ex = 1'b0;
    #1 chk("lu_t1_stall", 64'(stall3), 64'd1);
    tick();
    chk("lu_t2_stall", 64'(stall3), 64'd1);
    tick();
    chk("lu_t3_stall", 64'(stall3), 64'd0);
    chk("lu_count3", 64'(cnt3), 64'd3);
    chk("lu_count2", 64'(cnt2), 64'd2);

    mem_read_ex = 1'b1; rs_used_id = 2'b01;
    #1 chk("lu_unused", 64'(stall3), 64'd0);
    tick();
    mem_read_ex = 1'b0; rs_used_id = 2'b10;

    arst = 1'b1;
    tick();
    arst = 1'b0;
    #1 chk("hold_cnt0", 64'(cnt2), 64'd0);
    mem_read_ex = 1'b1;
    #1 chk("hold_t0", 64'(stall2), 64'd1);
    tick();
    mem_read_ex = 1'b0; hold = 1'b1;
    #1 chk("hold_t1_stall", 64'(stall2), 64'd1);
    chk("hold_t1_flush", 64'(flush2), 64'd0);
    tick();
    chk("hold_t2_stall", 64'(stall2), 64'd1);
    chk("hold_t2_flush", 64'(flush2), 64'd0);
    tick();
    hold = 1'b0;
    #1 chk("hold_t3_flush", 64'(flush2), 64'd1);
    tick();
    chk("hold_t4_stall", 64'(stall2), 64'd0);
    chk("hold_count", 64'(cnt2), 64'd4);
    repeat (3) tick();

    mem_read_ex = 1'b1;
    tick();
    mem_read_ex = 1'b0;
    #1 chk("mid_stall", 64'(stall2), 64'd1);
    arst = 1'b1;
    #1 chk("arst_stall2", 64'(stall2), 64'd0);
    chk("arst_stall3", 64'(stall3), 64'd0);
    chk("arst_flush2", 64'(flush2), 64'd0);
    chk("arst_count2", 64'(cnt2), 64'd0);
    tick();
    arst = 1'b0;
    #1 chk("post_rst", 64'(stall2), 64'd0);
    tick();

    mem_read_ex = 1'b1;
    repeat (20) tick();
    chk("sat_count2", 64'(cnt2), 64'd15);
    chk("cnt_count3", 64'(cnt3), 64'd20);
    mem_read_ex = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
